// File: rtl/ok_reg_bank.sv
// Register bank behind the host register bridge: host-writable config registers
// with level/pulse modes and update/ack handshakes, read-only status words, and a CTRL word.
module ok_reg_bank #(
    parameter int unsigned       N_CONF     = 8,
    parameter int unsigned       N_STAT     = 4,
    parameter int unsigned       DATA_W     = 32,
    parameter logic [31:0]       BASE_ADDR  = 32'h0,
    parameter logic [N_CONF-1:0] PULSE_MASK = '0
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [31:0]                                   ep_address,
    input  logic                                          ep_write,
    input  logic [31:0]                                   ep_dataout,
    input  logic                                          ep_read,
    output logic [31:0]                                   ep_datain,
    output logic [N_CONF*DATA_W-1:0]                      conf_data,
    output logic [N_CONF-1:0]                             conf_update,
    input  logic [N_CONF-1:0]                             conf_ack,
    // With N_STAT = 0 the port keeps one unused word so it never has zero width.
    input  logic [((N_STAT > 0) ? N_STAT : 1)*DATA_W-1:0] stat_data,
    output logic [15:0]                                   err_count
);

    localparam int unsigned CTRL_OFF     = N_CONF + N_STAT;
    localparam logic [31:0] ILLEGAL_DATA = 32'hBAD0_ADD0;

    logic [DATA_W-1:0] conf_q [N_CONF];
    logic [31:0]       offset;
    logic              in_map;
    logic              is_conf;
    logic              is_ctrl;
    logic              wr_illegal;
    logic              rd_illegal;
    logic              ctrl_clear;
    logic [31:0]       rd_data;
    logic [16:0]       err_sum;

    // The address must be checked against BASE_ADDR itself so a wrapped subtraction is never legal.
    assign offset     = ep_address - BASE_ADDR;
    assign in_map     = (ep_address >= BASE_ADDR) && (offset <= CTRL_OFF);
    assign is_conf    = in_map && (offset < N_CONF);
    assign is_ctrl    = in_map && (offset == CTRL_OFF);
    assign wr_illegal = ep_write && !is_conf && !is_ctrl;
    assign rd_illegal = ep_read && !in_map;
    assign ctrl_clear = ep_write && is_ctrl && ep_dataout[31];
    assign err_sum    = {1'b0, err_count} + 17'(wr_illegal) + 17'(rd_illegal);

    for (genvar g = 0; g < N_CONF; g++) begin : g_pack
        assign conf_data[g*DATA_W +: DATA_W] = conf_q[g];
    end

    // Read mux sees pre-edge state, so a same-cycle write returns the old value.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        rd_data = ILLEGAL_DATA;
        for (int unsigned i = 0; i < N_CONF; i++) begin
            if (is_conf && offset == 32'(i)) rd_data = 32'(conf_q[i]);
        end
        for (int unsigned j = 0; j < N_STAT; j++) begin
            if (in_map && offset == 32'(N_CONF + j)) rd_data = 32'(stat_data[j*DATA_W +: DATA_W]);
        end
        if (is_ctrl) begin
            rd_data = {err_count, 16'b0};
            for (int unsigned k = 0; k < N_CONF && k < 16; k++) rd_data[k] = conf_update[k];
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is written with non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            // NOTE: the config array is reset because its contents are visible on conf_data straight out of reset.
            for (int unsigned i = 0; i < N_CONF; i++) conf_q[i] <= '0;
            conf_update <= '0;
            ep_datain   <= '0;
            err_count   <= '0;
        end else begin
            if (ep_read) ep_datain <= rd_data;

            // A write beats both the pulse self-clear and a same-cycle ack.
            for (int unsigned i = 0; i < N_CONF; i++) begin
                if (ep_write && is_conf && offset == 32'(i)) begin
                    conf_q[i]      <= ep_dataout[DATA_W-1:0];
                    conf_update[i] <= 1'b1;
                end else begin
                    if (PULSE_MASK[i]) conf_q[i] <= '0;
                    if (conf_ack[i]) conf_update[i] <= 1'b0;
                end
            end

            if (ctrl_clear)       err_count <= '0;
            else if (err_sum[16]) err_count <= 16'hFFFF;
            else                  err_count <= err_sum[15:0];
        end
    end

endmodule

// File: doc/ok_reg_bank.md
Name: ok_reg_bank

Overview:
- Parametrised register bank that sits behind the host register-bridge endpoint.
- Decodes the bridge address/strobe bus into N_CONF host-writable configuration registers and N_STAT read-only status words, plus one control word.
- Gives each config register a level or pulse mode and a per-register update/ack handshake toward core logic in the same clock domain.
- Returns registered read data to the bridge and counts illegal accesses.

Parameters:
- N_CONF, 8: number of config registers (1..32).
- N_STAT, 4: number of status words (0..32).
- DATA_W, 32: config/status register width (1..32). Zero-extended on read, truncated to DATA_W LSBs on write.
- BASE_ADDR, 32'h0: first address of the bank.
- PULSE_MASK, 0 (N_CONF bits): bit i=1 makes config register i self-clear one cycle after a write.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ep_address  in  32  bridge register address.
- ep_write  in  1  bridge write strobe, one cycle per access.
- ep_dataout  in  32  bridge write data.
- ep_read  in  1  bridge read strobe, one cycle per access.
- ep_datain  out  32  read data returned to the bridge.
- conf_data  out  N_CONF*DATA_W  config register contents; register i is at [i*DATA_W +: DATA_W].
- conf_update  out  N_CONF  per-register "new value written" flag.
- conf_ack  in  N_CONF  core acknowledge; clears the matching conf_update bit.
- stat_data  in  N_STAT*DATA_W  status inputs, packed the same way as conf_data.
- err_count  out  16  illegal-access counter, saturating.

Behaviour:
- Reset: synchronous, active-high, dominates all other inputs. The following outputs are 0 the cycle after reset is sampled high:
  - conf_data
  - conf_update
  - ep_datain
  - err_count
- Reset mid-access: any in-flight read result is discarded.
- Address map, with offset = ep_address - BASE_ADDR:
  - offset 0..N_CONF-1: config register i, read/write.
  - offset N_CONF..N_CONF+N_STAT-1: status word j, read-only.
  - offset N_CONF+N_STAT: CTRL word.
  - Any other address, including ep_address < BASE_ADDR, is illegal.
- CTRL word:
  - Read returns {err_count[15:0], 16'b0} with conf_update zero-extended into bits [N_CONF-1:0] of the low half. Requires N_CONF ≤ 16 when CTRL is read; N_CONF > 16 is truncated to the low 16 update bits.
  - Write with bit 31 set clears err_count. Other bits are ignored.
- Config write at cycle t (ep_write=1):
  - conf_data[i] takes ep_dataout[DATA_W-1:0] at t+1.
  - conf_update[i] = 1 at t+1.
  - Pulse registers (PULSE_MASK[i]=1): value visible for exactly the t+1 cycle, then returns to 0 at t+2. conf_update still sets and holds until acked.
- Update handshake:
  - conf_update[i] stays 1 until a cycle with conf_ack[i]=1 and no write to register i.
  - Write and ack to the same register in the same cycle: flag stays 1, because the new value is unacknowledged.
  - conf_ack[i] with flag already 0 has no effect.
- Writes to a status address are illegal.
- Read:
  - ep_read at cycle t → ep_datain valid at t+1, one-cycle latency.
  - ep_datain holds its value until the next read completes.
  - Status reads return stat_data as sampled at cycle t.
  - Illegal read returns 32'hBAD0_ADD0.
- Simultaneous ep_read and ep_write in the same cycle: the write commits; the read returns the pre-write value. Applies to the same or different addresses.
- err_count:
  - +1 per illegal read or illegal write; saturates at 16'hFFFF.
  - Illegal read and illegal write in the same cycle count as +2, still saturating.
  - A CTRL clear in the same cycle as an illegal access: clear wins, and the result is 0.
- No backpressure: the bank accepts one read and one write every cycle.

Test Plan:
- Reset then read all N_CONF addresses (BASE_ADDR=0x40): each ep_datain = 0; conf_update = 0; err_count = 0.
- Write 0xA5A5_1234 to addr 0x42 (DATA_W=16): next cycle conf_data[2] = 0x1234 and conf_update[2] = 1. Read 0x42 → 0x0000_1234. Pulse conf_ack[2] → conf_update[2] = 0 the next cycle.
- PULSE_MASK bit3 set, write 0xFF to 0x43: conf_data[3] = 0xFF for one cycle, then 0. conf_update[3] stays 1 until acked.
- Same-cycle write 0x55 and read to 0x41 (old value 0x11): read returns 0x11; a subsequent read returns 0x55. Write plus ack to 0x41 in the same cycle leaves conf_update[1] = 1.
- stat_data[0] = 0xCAFE, read addr 0x48: returns 0x0000_CAFE. Write to 0x48: err_count = 1. Read 0x100 → 0xBAD0_ADD0, err_count = 2.
- Force err_count to 0xFFFE, issue 3 illegal accesses → err_count = 0xFFFF. Write 0x8000_0000 to CTRL (0x4C) → err_count = 0. Assert reset during a read → ep_datain = 0.
